axi_lite_cmd_master: RTL and testbench

//  Single-outstanding AXI4-Lite master that turns a simple valid/ready command stream into AXI4-Lite write/read bursts of one beat.

---
 rtl/axi_lite_cmd_master.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_master
//
// This is an AXI4-Lite master that handles one transaction at a time. It
// turns a valid/ready command stream into single-beat AXI4-Lite writes or
// reads, and returns exactly one response per command on a valid/ready
// response stream.
//
// A watchdog limits how long the master waits in each AXI waiting state.
// If the limit is reached, the transaction is aborted and reported as a
// timeout.
//
// Ports
//   aclk, aresetn          clock (rising edge), asynchronous active-low reset
//
//   cmd_valid/cmd_ready    command handshake
//   cmd_write              1 = write, 0 = read
//   cmd_addr               target address
//   cmd_wdata              write data (not used for reads)
//
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata              read data (0 for writes and timeouts)
//   rsp_resp               AXI response (2'b10 on timeout)
//   rsp_timeout            1 = transaction aborted by the watchdog
//
//   m_axi_aw*/w*/b*        AXI4-Lite write address, write data and write
//                          response channels
//   m_axi_ar*/r*           AXI4-Lite read address and read data channels
// ---------------------------------------------------------------------------
module axi_lite_cmd_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [DATA_W-1:0] m_axi_wdata,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    // The abort fires on the edge where the counter would reach TIMEOUT.
    // As a result, a valid that is never accepted stays high for exactly
    // TIMEOUT cycles.
    localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

    logic [2:0]        r_state;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_cmdReady;
    logic              r_awValid;
    logic              r_wValid;
    logic              r_bReady;
    logic              r_arValid;
    logic              r_rReady;
    logic [ADDR_W-1:0] r_awAddr;
    logic [DATA_W-1:0] r_wData;
    logic [ADDR_W-1:0] r_arAddr;
    logic              r_rspValid;
    logic [DATA_W-1:0] r_rspRdata;
    logic [1:0]        r_rspResp;
    logic              r_rspTimeout;

    logic w_awDone;
    logic w_wDone;
    logic w_waiting;
    logic w_advance;
    logic w_expire;

    // Each write channel counts as done once its handshake has happened,
    // either on an earlier edge or on the current one.
    assign w_awDone = !r_awValid || m_axi_awready;
    assign w_wDone  = !r_wValid  || m_axi_wready;

    assign w_waiting = (r_state == ST_WR_REQ)  || (r_state == ST_WR_RESP) ||
                       (r_state == ST_RD_REQ)  || (r_state == ST_RD_DATA);

    // A state that makes progress on this edge takes priority over the
    // watchdog. A handshake that lands on the final allowed cycle is
    // therefore still honoured.
    always_comb begin
        w_advance = 1'b0;
        case (r_state)
            ST_WR_REQ:  w_advance = w_awDone && w_wDone;
            ST_WR_RESP: w_advance = m_axi_bvalid && r_bReady;
            ST_RD_REQ:  w_advance = m_axi_arready && r_arValid;
            ST_RD_DATA: w_advance = m_axi_rvalid && r_rReady;
            default:    w_advance = 1'b0;
        endcase
    end

    assign w_expire = (TIMEOUT != 0) && w_waiting && (r_wdog == WDOG_LAST);

    // Main control state machine.
    //
    // The watchdog counts every cycle spent in a waiting state. It saturates
    // instead of wrapping. Every state transition clears it, which is why the
    // clear appears in each transition branch below; a later non-blocking
    // assignment in the same cycle overrides the earlier increment.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_wdog       <= '0;
            r_cmdReady   <= 1'b0;
            r_awValid    <= 1'b0;
            r_wValid     <= 1'b0;
            r_bReady     <= 1'b0;
            r_arValid    <= 1'b0;
            r_rReady     <= 1'b0;
            r_awAddr     <= '0;
            r_wData      <= '0;
            r_arAddr     <= '0;
            r_rspValid   <= 1'b0;
            r_rspRdata   <= '0;
            r_rspResp    <= 2'b00;
            r_rspTimeout <= 1'b0;
        end else begin
            if (!w_waiting) begin
                r_wdog <= '0;
            end else if (r_wdog != {WDOG_W{1'b1}}) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end

            if (w_expire && !w_advance) begin
                // Abort: drop every AXI valid and ready. Because RSP never
                // looks at the slave, any handshake the slave makes late is
                // ignored.
                r_awValid    <= 1'b0;
                r_wValid     <= 1'b0;
                r_bReady     <= 1'b0;
                r_arValid    <= 1'b0;
                r_rReady     <= 1'b0;
                r_rspValid   <= 1'b1;
                r_rspRdata   <= '0;
                r_rspResp    <= 2'b10;
                r_rspTimeout <= 1'b1;
                r_wdog       <= '0;
                r_state      <= ST_RSP;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_valid && r_cmdReady) begin
                            r_cmdReady <= 1'b0;
                            r_wdog     <= '0;
                            if (cmd_write) begin
                                r_awAddr  <= cmd_addr;
                                r_wData   <= cmd_wdata;
                                r_awValid <= 1'b1;
                                r_wValid  <= 1'b1;
                                r_state   <= ST_WR_REQ;
                            end else begin
                                r_arAddr  <= cmd_addr;
                                r_arValid <= 1'b1;
                                r_state   <= ST_RD_REQ;
                            end
                        end else begin
                            r_cmdReady <= 1'b1;
                        end
                    end
                    ST_WR_REQ: begin
                        if (w_advance) begin
                            r_awValid <= 1'b0;
                            r_wValid  <= 1'b0;
                            r_bReady  <= 1'b1;
                            r_wdog    <= '0;
                            r_state   <= ST_WR_RESP;
                        end else begin
                            if (r_awValid && m_axi_awready) begin
                                r_awValid <= 1'b0;
                            end
                            if (r_wValid && m_axi_wready) begin
                                r_wValid <= 1'b0;
                            end
                        end
                    end
                    ST_WR_RESP: begin
                        if (w_advance) begin
                            r_bReady     <= 1'b0;
                            r_rspValid   <= 1'b1;
                            r_rspRdata   <= '0;
                            r_rspResp    <= m_axi_bresp;
                            r_rspTimeout <= 1'b0;
                            r_wdog       <= '0;
                            r_state      <= ST_RSP;
                        end
                    end
                    ST_RD_REQ: begin
                        if (w_advance) begin
                            r_arValid <= 1'b0;
                            r_rReady  <= 1'b1;
                            r_wdog    <= '0;
                            r_state   <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_advance) begin
                            r_rReady     <= 1'b0;
                            r_rspValid   <= 1'b1;
                            r_rspRdata   <= m_axi_rdata;
                            r_rspResp    <= m_axi_rresp;
                            r_rspTimeout <= 1'b0;
                            r_wdog       <= '0;
                            r_state      <= ST_RSP;
                        end
                    end
                    ST_RSP: begin
                        // cmd_ready rises together with the return to IDLE,
                        // so the next command can be accepted on the very
                        // next edge.
                        if (rsp_ready) begin
                            r_rspValid <= 1'b0;
                            r_cmdReady <= 1'b1;
                            r_wdog     <= '0;
                            r_state    <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd_ready     = r_cmdReady;
    assign rsp_valid     = r_rspValid;
    assign rsp_rdata     = r_rspRdata;
    assign rsp_resp      = r_rspResp;
    assign rsp_timeout   = r_rspTimeout;
    assign m_axi_awvalid = r_awValid;
    assign m_axi_awaddr  = r_awAddr;
    assign m_axi_wvalid  = r_wValid;
    assign m_axi_wdata   = r_wData;
    assign m_axi_bready  = r_bReady;
    assign m_axi_arvalid = r_arValid;
    assign m_axi_araddr  = r_arAddr;
    assign m_axi_rready  = r_rReady;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_cmd_master
//
// This bench runs directed commands through axi_lite_cmd_master, which is
// attached to a behavioural AXI4-Lite slave with configurable ready delays.
//
// When each command is accepted, its expected response is pushed onto a
// queue. When the DUT presents a response, the bench pops the expectation
// and compares it.
// ---------------------------------------------------------------------------
module tb_axi_lite_cmd_master;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              aclk;
    logic              aresetn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [DATA_W-1:0] m_axi_wdata;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [1:0]        resp;
        logic              timeout;
    } rspExp_t;

    rspExp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    // Configuration knobs for the slave model, plus the slave's own record
    // of what it has observed.
    int                awDelay   = 0;
    int                wDelay    = 0;
    int                bDelay    = 0;
    bit                arEnable  = 1'b1;
    logic [1:0]        bRespCfg  = 2'b00;
    logic [1:0]        rRespCfg  = 2'b00;
    int                awHsCount = 0;
    int                wHsCount  = 0;
    logic [ADDR_W-1:0] capAwAddr = '0;
    logic [DATA_W-1:0] capWData  = '0;
    logic [ADDR_W-1:0] capArAddr = '0;
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    axi_lite_cmd_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp)
    );

    // 100 MHz clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Hard stop in case something gets stuck outside a bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: observed no finish, expected finish before 500us");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Behavioural AXI4-Lite slave. It acts on each falling edge.
    //
    // Because DUT outputs are registered, whatever valid/ready pair the slave
    // sees at a falling edge is exactly what the next rising edge will
    // sample. The slave therefore predicts the handshakes for that rising
    // edge (step 3) and applies their effects at the following falling
    // edge (step 1).
    initial begin : slaveModel
        int awWait;
        int wWait;
        int bWait;
        bit gotAw;
        bit gotW;
        bit pAwHs;
        bit pWHs;
        bit pBHs;
        bit pArHs;
        bit pRHs;
        awWait = 0; wWait = 0; bWait = 0;
        gotAw  = 1'b0; gotW = 1'b0;
        pAwHs  = 1'b0; pWHs = 1'b0; pBHs = 1'b0; pArHs = 1'b0; pRHs = 1'b0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awWait = 0; wWait = 0; bWait = 0;
                gotAw  = 1'b0; gotW = 1'b0;
                pAwHs  = 1'b0; pWHs = 1'b0; pBHs = 1'b0; pArHs = 1'b0; pRHs = 1'b0;
                m_axi_awready = 1'b0;
                m_axi_wready  = 1'b0;
                m_axi_bvalid  = 1'b0;
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
            end else begin
                // Step 1: apply the handshakes that completed on the last
                // rising edge.
                if (pBHs) begin
                    m_axi_bvalid = 1'b0;
                    gotAw = 1'b0;
                    gotW  = 1'b0;
                    bWait = 0;
                end
                if (pRHs) m_axi_rvalid = 1'b0;
                if (pAwHs) begin
                    gotAw = 1'b1;
                    awHsCount++;
                end
                if (pWHs) begin
                    gotW = 1'b1;
                    wHsCount++;
                end
                if ((pAwHs || pWHs) && gotAw && gotW) mem[capAwAddr] = capWData;
                if (pArHs) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = mem.exists(capArAddr) ? mem[capArAddr] : '0;
                    m_axi_rresp  = rRespCfg;
                end

                // Step 2: drive the readies and write responses for the
                // coming rising edge.
                if (m_axi_awvalid) begin
                    if (awWait >= awDelay) m_axi_awready = 1'b1;
                    else begin
                        m_axi_awready = 1'b0;
                        awWait++;
                    end
                end else begin
                    m_axi_awready = 1'b0;
                    awWait = 0;
                end
                if (m_axi_wvalid) begin
                    if (wWait >= wDelay) m_axi_wready = 1'b1;
                    else begin
                        m_axi_wready = 1'b0;
                        wWait++;
                    end
                end else begin
                    m_axi_wready = 1'b0;
                    wWait = 0;
                end
                m_axi_arready = m_axi_arvalid && arEnable;
                if (gotAw && gotW && !m_axi_bvalid) begin
                    if (bWait >= bDelay) begin
                        m_axi_bvalid = 1'b1;
                        m_axi_bresp  = bRespCfg;
                    end else begin
                        bWait++;
                    end
                end

                // Step 3: predict which handshakes the next rising edge
                // will complete.
                pAwHs = m_axi_awvalid && m_axi_awready;
                pWHs  = m_axi_wvalid  && m_axi_wready;
                pBHs  = m_axi_bvalid  && m_axi_bready;
                pArHs = m_axi_arvalid && m_axi_arready;
                pRHs  = m_axi_rvalid  && m_axi_rready;
                if (pAwHs) capAwAddr = m_axi_awaddr;
                if (pWHs)  capWData  = m_axi_wdata;
                if (pArHs) capArAddr = m_axi_araddr;
            end
        end
    end

    // Advance to just after the falling edge. Outputs from both the DUT and
    // the slave are settled at that point.
    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] allOutputs();
        return 128'({cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
                     m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata, m_axi_bready,
                     m_axi_arvalid, m_axi_araddr, m_axi_rready});
    endfunction

    // Present one command and hold it until it is accepted. The expectation
    // is queued on the accepting edge. The task returns on the falling edge
    // just after acceptance.
    task automatic applyStimulus(input string tag, input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input rspExp_t exp,
                                 output int acceptWait);
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = addr;
        cmd_wdata  = wdata;
        acceptWait = 0;
        while (cmd_ready !== 1'b1 && acceptWait < 100) begin
            tick();
            acceptWait++;
        end
        checkOutput({tag, ".accept"}, 128'(cmd_ready), 128'(1));
        if (cmd_ready === 1'b1) sb.push_back(exp);
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
    endtask

    // Wait for a response and compare it against the scoreboard.
    // Optionally hold rsp_ready low for a number of cycles first, checking
    // the response stays stable, then complete the handshake.
    task automatic collectResponse(input string tag, input int holdCycles);
        int      waitCnt;
        rspExp_t exp;
        waitCnt = 0;
        while (rsp_valid !== 1'b1 && waitCnt < 100) begin
            tick();
            waitCnt++;
        end
        checkOutput({tag, ".rspValid"}, 128'(rsp_valid), 128'(1));
        checkOutput({tag, ".sbDepth"}, 128'(sb.size()), 128'(1));
        if (rsp_valid === 1'b1 && sb.size() > 0) begin
            exp = sb.pop_front();
            for (int i = 0; i <= holdCycles; i++) begin
                if (i > 0) tick();
                checkOutput({tag, ".rdata"},   128'(rsp_rdata),   128'(exp.rdata));
                checkOutput({tag, ".resp"},    128'(rsp_resp),    128'(exp.resp));
                checkOutput({tag, ".timeout"}, 128'(rsp_timeout), 128'(exp.timeout));
                if (holdCycles > 0) begin
                    checkOutput({tag, ".holdValid"},    128'(rsp_valid), 128'(1));
                    checkOutput({tag, ".holdCmdReady"}, 128'(cmd_ready), 128'(0));
                end
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            checkOutput({tag, ".rspDrop"},   128'(rsp_valid), 128'(0));
            checkOutput({tag, ".cmdReady"},  128'(cmd_ready), 128'(1));
        end
    endtask

    // Directed test sequence.
    initial begin : stimulus
        int      acc;
        int      cnt;
        int      aw0;
        int      w0;
        rspExp_t e;

        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;

        tick();
        tick();
        checkOutput("resetOutputs", allOutputs(), 128'(0));
        aresetn = 1'b1;
        tick();
        checkOutput("idleCmdReady", 128'(cmd_ready), 128'(1));

        $display("[TB] basic write, slave ready immediately");
        aw0 = awHsCount;
        w0  = wHsCount;
        e   = '{rdata: 32'h0, resp: 2'b00, timeout: 1'b0};
        applyStimulus("wr1", 1'b1, 16'h0001, 32'h0000_000A, e, acc);
        collectResponse("wr1", 0);
        checkOutput("wr1.awCount", 128'(awHsCount - aw0), 128'(1));
        checkOutput("wr1.wCount",  128'(wHsCount - w0),   128'(1));
        checkOutput("wr1.awaddr",  128'(capAwAddr), 128'(16'h0001));
        checkOutput("wr1.wdata",   128'(capWData),  128'(32'h0000_000A));

        $display("[TB] write then read back");
        e = '{rdata: 32'h0, resp: 2'b00, timeout: 1'b0};
        applyStimulus("wr2", 1'b1, 16'hAA0F, 32'h110A_0FB9, e, acc);
        collectResponse("wr2", 0);
        e = '{rdata: 32'h110A_0FB9, resp: 2'b00, timeout: 1'b0};
        applyStimulus("rd2", 1'b0, 16'hAA0F, 32'h0, e, acc);
        collectResponse("rd2", 0);

        $display("[TB] wready three cycles after awready");
        awDelay = 0;
        wDelay  = 3;
        aw0 = awHsCount;
        w0  = wHsCount;
        e   = '{rdata: 32'h0, resp: 2'b00, timeout: 1'b0};
        applyStimulus("wr3", 1'b1, 16'h0100, 32'h0BAD_F00D, e, acc);
        checkOutput("wr3.bothValid", 128'({m_axi_awvalid, m_axi_wvalid}), 128'(2'b11));
        tick();
        checkOutput("wr3.awFirst", 128'({m_axi_awvalid, m_axi_wvalid}), 128'(2'b01));
        tick();
        checkOutput("wr3.wHeld", 128'({m_axi_awvalid, m_axi_wvalid}), 128'(2'b01));
        collectResponse("wr3", 0);
        checkOutput("wr3.awCount", 128'(awHsCount - aw0), 128'(1));
        checkOutput("wr3.wCount",  128'(wHsCount - w0),   128'(1));

        $display("[TB] awready three cycles after wready");
        awDelay = 3;
        wDelay  = 0;
        e = '{rdata: 32'h0, resp: 2'b00, timeout: 1'b0};
        applyStimulus("wr4", 1'b1, 16'h0200, 32'h1234_5678, e, acc);
        checkOutput("wr4.bothValid", 128'({m_axi_awvalid, m_axi_wvalid}), 128'(2'b11));
        tick();
        checkOutput("wr4.wFirst", 128'({m_axi_awvalid, m_axi_wvalid}), 128'(2'b10));
        tick();
        checkOutput("wr4.awHeld", 128'({m_axi_awvalid, m_axi_wvalid}), 128'(2'b10));
        collectResponse("wr4", 0);
        awDelay = 0;
        e = '{rdata: 32'h1234_5678, resp: 2'b00, timeout: 1'b0};
        applyStimulus("rd4", 1'b0, 16'h0200, 32'h0, e, acc);
        collectResponse("rd4", 0);

        $display("[TB] arready never asserted, watchdog abort");
        arEnable = 1'b0;
        e = '{rdata: 32'h0, resp: 2'b10, timeout: 1'b1};
        applyStimulus("to1", 1'b0, 16'h1234, 32'h0, e, acc);
        cnt = 0;
        while (m_axi_arvalid === 1'b1 && cnt < 30) begin
            cnt++;
            tick();
        end
        checkOutput("to1.arvalidCycles", 128'(cnt), 128'(TIMEOUT));
        checkOutput("to1.rreadyLow", 128'(m_axi_rready), 128'(0));
        collectResponse("to1", 0);
        arEnable = 1'b1;

        $display("[TB] rsp_ready held low five cycles");
        e = '{rdata: 32'h110A_0FB9, resp: 2'b00, timeout: 1'b0};
        applyStimulus("hold", 1'b0, 16'hAA0F, 32'h0, e, acc);
        collectResponse("hold", 5);
        e = '{rdata: 32'h0000_000A, resp: 2'b00, timeout: 1'b0};
        applyStimulus("next", 1'b0, 16'h0001, 32'h0, e, acc);
        checkOutput("next.acceptWait", 128'(acc), 128'(0));
        collectResponse("next", 0);

        $display("[TB] error responses pass through");
        bRespCfg = 2'b10;
        e = '{rdata: 32'h0, resp: 2'b10, timeout: 1'b0};
        applyStimulus("slverr", 1'b1, 16'h0002, 32'h00C0_FFEE, e, acc);
        collectResponse("slverr", 0);
        bRespCfg = 2'b00;
        rRespCfg = 2'b11;
        e = '{rdata: 32'h00C0_FFEE, resp: 2'b11, timeout: 1'b0};
        applyStimulus("decerr", 1'b0, 16'h0002, 32'h0, e, acc);
        collectResponse("decerr", 0);
        rRespCfg = 2'b00;

        $display("[TB] reset during WR_RESP");
        bDelay = 30;
        e = '{rdata: 32'h0, resp: 2'b00, timeout: 1'b0};
        applyStimulus("rst", 1'b1, 16'h5555, 32'hDEAD_BEEF, e, acc);
        cnt = 0;
        while (m_axi_bready !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput("rst.inWrResp", 128'(m_axi_bready), 128'(1));
        aresetn = 1'b0;
        #1;
        checkOutput("rst.asyncOutputs", allOutputs(), 128'(0));
        sb.delete();
        tick();
        tick();
        aresetn = 1'b1;
        bDelay  = 0;
        tick();
        e = '{rdata: 32'h110A_0FB9, resp: 2'b00, timeout: 1'b0};
        applyStimulus("postRst", 1'b0, 16'hAA0F, 32'h0, e, acc);
        collectResponse("postRst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
